ntt_coeff_buffer: RTL
=====================

// Module: ntt_coeff_buffer
// PURPOSE
//  Memory-side responder for the streaming NTT memory wrapper. Loads N=2**LOGN
//  coefficients from a host valid/ready stream into an input bank, then drives the
//  wrapper (start/rst level controls) while serving its read addresses with
//  RD_LAT-cycle data and capturing its write-backs into an output bank. Finally it
//  streams the N results back to the host in address order.
// PARAMETERS
//  LOGQ    64  coefficient width
//  LOGN    10  log2 of ring size N
//  RD_LAT  2   read-port latency seen by the wrapper (>=1); must equal wrapper DELAY_BRAM
//  AW      derived ((LOGN<9)?10:LOGN); wrapper address width
// PORTS
//  clk            in   1     clock
//  rst            in   1     asynchronous reset, active low (asserted at 0)
//  s_valid        in   1     host load word valid
//  s_ready        out  1     buffer accepts load word
//  s_data         in   LOGQ  host load word
//  m_valid        out  1     result word valid
//  m_ready        in   1     host accepts result word
//  m_data         out  LOGQ  result word
//  ntt_rst        out  1     synchronous active-high reset to wrapper
//  ntt_start      out  1     wrapper start level
//  ntt_rd_addr    in   AW    wrapper read_address
//  ntt_rd_data    out  LOGQ  data to wrapper data64_in
//  ntt_wr_addr    in   AW    wrapper write_address
//  ntt_wea        in   1     wrapper write enable
//  ntt_wr_data    in   LOGQ  wrapper data64_out
//  ntt_finish     in   1     wrapper finish (level)
//  busy           out  1     high in LOAD..UNLOAD until last result accepted
//  done           out  1     one-cycle pulse after last result handshake
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; s_ready=m_valid=ntt_start=done=busy=0,
//   ntt_rst=1, m_data=ntt_rd_data=0, counters 0. RAM contents not cleared.
//  FSM: IDLE -> LOAD (first clock after reset release) -> RUN -> UNLOAD -> IDLE.
//  IDLE: ntt_rst=1. Lasts exactly one cycle.
//  LOAD: s_ready=1; each s_valid&&s_ready writes bank A[ld_cnt], ld_cnt++.
//   Handshake of word N-1 -> RUN next cycle, s_ready drops same edge. ntt_rst=1.
//  RUN: ntt_rst=0, ntt_start=1 (level, held for whole state; wrapper needs a held level).
//   ntt_rd_data = A[ntt_rd_addr[LOGN-1:0]] exactly RD_LAT cycles after address;
//   addresses >=N use low LOGN bits (wrap to 0).
//   ntt_wea=1 writes ntt_wr_data to B[ntt_wr_addr[LOGN-1:0]]; wea outside RUN ignored.
//   ntt_finish=1 -> UNLOAD next cycle; ntt_start=0 and ntt_rst=1 from UNLOAD on.
//   Write on the same cycle as finish is still captured.
//  UNLOAD: streams B[0..N-1] in order; m_data stable while m_valid&&!m_ready.
//   First m_valid <= RD_LAT+1 cycles after entry; sustains 1 word/cycle with
//   m_ready=1 (prefetch + 2-entry skid). Handshake of word N-1 -> IDLE, done=1 for 1 cycle.
//  s_valid outside LOAD ignored (s_ready=0); m_ready outside UNLOAD ignored.
//  Counters LOGN+1 bits; ld_cnt/ul_cnt saturate at N, never wrap mid-state.
//  Async reset mid-operation: return to IDLE immediately, partial load/unload discarded.
//  Back-to-back jobs: IDLE->LOAD guarantees >=1 cycle of ntt_rst=1 before the next RUN.
// TESTING
//  T1 reset: hold rst=0 with random inputs -> outputs as reset list; one clock after
//     release s_ready=1, busy=1.
//  T2 LOGN=4: load 0..15, stub wrapper returns x+1 at addr x -> results 1..16 in order, done pulses once.
//  T3 read latency: in RUN drive ntt_rd_addr=5 at cycle t -> ntt_rd_data=A[5] at t+RD_LAT;
//     addr=16 -> A[0].
//  T4 backpressure: random m_ready (50%) -> m_data never changes while m_valid&&!m_ready;
//     16 words, no loss/dup.
//  T5 stray traffic: s_valid in RUN, ntt_wea in LOAD/UNLOAD -> banks unchanged, s_ready=0.
//  T6 rst low mid-UNLOAD after word 7 -> IDLE; next job reloads and returns correct 16 words.

Source files
------------

// File: rtl/ntt_coeff_buffer.sv
// Memory-side responder for the streaming NTT wrapper: loads N coefficients into bank A, serves
// wrapper reads from A with RD_LAT latency, captures write-backs into bank B and streams B back out.
module ntt_coeff_buffer #(
  parameter int LOGQ   = 64,
  parameter int LOGN   = 10,
  parameter int RD_LAT = 2,
  localparam int AW    = (LOGN < 9) ? 10 : LOGN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [LOGQ-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [LOGQ-1:0] m_data,
  output logic            ntt_rst,
  output logic            ntt_start,
  input  logic [AW-1:0]   ntt_rd_addr,
  output logic [LOGQ-1:0] ntt_rd_data,
  input  logic [AW-1:0]   ntt_wr_addr,
  input  logic            ntt_wea,
  input  logic [LOGQ-1:0] ntt_wr_data,
  input  logic            ntt_finish,
  output logic            busy,
  output logic            done
);

  localparam int N = 1 << LOGN;
  localparam logic [LOGN:0] LAST = (LOGN+1)'(N - 1);
  localparam logic [LOGN:0] FULL = (LOGN+1)'(N);
  localparam logic [LOGN:0] ONE  = (LOGN+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

  state_t          state;
  logic [LOGN:0]   ld_cnt;
  logic [LOGN:0]   ul_cnt;
  logic [LOGN:0]   rd_ptr;
  logic [LOGQ-1:0] bank_a [N];
  logic [LOGQ-1:0] bank_b [N];
  logic [LOGQ-1:0] rd_pipe [RD_LAT];
  logic [LOGQ-1:0] rd_q;
  logic [LOGQ-1:0] sk_data;
  logic            rd_vld;
  logic            sk_vld;
  logic            pop;
  logic            issue;
  logic [1:0]      fill;
  logic            unused_addr_bits;

  // Only the low LOGN address bits select a bank entry; upper bits wrap.
  assign unused_addr_bits = ^{ntt_rd_addr, ntt_wr_addr};

  // Issue a B read only while output reg + skid + in-flight read stay within two entries.
  always_comb begin
    pop   = (state == UNLOAD) && m_valid && m_ready;
    fill  = 2'(m_valid) + 2'(sk_vld) + 2'(rd_vld) - 2'(pop);
    issue = (state == UNLOAD) && (rd_ptr != FULL) && (fill < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && s_valid && s_ready) bank_a[ld_cnt[LOGN-1:0]] <= s_data;
    if (state == RUN && ntt_wea) bank_b[ntt_wr_addr[LOGN-1:0]] <= ntt_wr_data;
    rd_q <= bank_b[rd_ptr[LOGN-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= bank_a[ntt_rd_addr[LOGN-1:0]];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign ntt_rd_data = rd_pipe[RD_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      ntt_start <= 1'b0;
      ntt_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ld_cnt    <= '0;
      ul_cnt    <= '0;
      rd_ptr    <= '0;
      rd_vld    <= 1'b0;
      sk_vld    <= 1'b0;
      sk_data   <= '0;
    end else begin
      done   <= 1'b0;
      rd_vld <= issue;
      if (issue) rd_ptr <= rd_ptr + ONE;
      case (state)
        IDLE: begin
          state   <= LOAD;
          s_ready <= 1'b1;
          busy    <= 1'b1;
          ntt_rst <= 1'b1;
          ld_cnt  <= '0;
          ul_cnt  <= '0;
          rd_ptr  <= '0;
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            if (ld_cnt != FULL) ld_cnt <= ld_cnt + ONE;
            if (ld_cnt == LAST) begin
              state     <= RUN;
              s_ready   <= 1'b0;
              ntt_rst   <= 1'b0;
              ntt_start <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ntt_finish) begin
            state     <= UNLOAD;
            ntt_start <= 1'b0;
            ntt_rst   <= 1'b1;
          end
        end
        UNLOAD: begin
          if (m_valid && !pop) begin
            if (rd_vld) begin
              sk_vld  <= 1'b1;
              sk_data <= rd_q;
            end
          end else if (sk_vld) begin
            m_data  <= sk_data;
            m_valid <= 1'b1;
            sk_vld  <= rd_vld;
            if (rd_vld) sk_data <= rd_q;
          end else begin
            m_valid <= rd_vld;
            if (rd_vld) m_data <= rd_q;
          end
          if (pop) begin
            if (ul_cnt != FULL) ul_cnt <= ul_cnt + ONE;
            if (ul_cnt == LAST) begin
              state   <= IDLE;
              done    <= 1'b1;
              busy    <= 1'b0;
              m_valid <= 1'b0;
              sk_vld  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
